cell_truth_table_sequencer: RTL and testbench
=============================================

# cell_truth_table_sequencer

Self-checking stimulus controller for the N-input standard-cell simulation flow. It walks a combinational cell under test through every input vector in binary order (MSB = first cell input, e.g. A1). Each vector is held for a programmable settle time before the cell output is sampled and compared against a caller-supplied truth table. Pass/fail and first-failure results replace per-vector console checking in cell benches and allow several cells to be qualified back-to-back from one top-level bench.

## Interface
- N_IN, default 4: number of cell inputs; legal 1..6; vector count = 2**N_IN.
- SETTLE_CYCLES, default 2: wait cycles between applying a vector and sampling; legal 0..255.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  cancel a run in progress.
- expected_tt  input  2**N_IN  bit i = expected cell output for vector i; latched when start is accepted.
- cell_out  input  1  output of the cell under test (e.g. ZN).
- stim  output  N_IN  vector driven to the cell inputs; stim[N_IN-1] goes to A1.
- busy  output  1  high from the start-accept edge until DONE is entered.
- done  output  1  one-cycle pulse at end of a complete run.
- pass  output  1  valid when done is high and held afterwards; 1 iff fail_count == 0.
- fail_count  output  N_IN+1  number of mismatching vectors.
- first_fail_valid  output  1  at least one mismatch recorded.
- first_fail_vec  output  N_IN  lowest-numbered failing vector.
- obs_tt  output  2**N_IN  observed truth table; see Configuration.

## Operation
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE + start: latch expected_tt, clear all results, set vec = 0, go to APPLY. start while busy is ignored.
- APPLY: drive stim = vec for one cycle. Go to SETTLE, or to SAMPLE if SETTLE_CYCLES == 0.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: compare cell_out with expected_tt[vec].
  - On mismatch, increment fail_count.
  - On the first mismatch of the run, set first_fail_valid and first_fail_vec = vec.
  - If vec == 2**N_IN-1, go to DONE; otherwise vec++ and go to APPLY.
- DONE: done = 1, busy = 0, go to IDLE. Results hold until the next accepted start or reset.
- stim holds its value through SETTLE and SAMPLE. It returns to 0 in IDLE/DONE.
- cell_out equal to X or Z in SAMPLE counts as a mismatch (4-state compare uses !==).
- abort, in any non-IDLE state: IDLE at the next edge, no done pulse, stim = 0, all results cleared. abort takes priority over the state transition in the same cycle.
- rst, including mid-run: same effect as abort, plus clears the latched expected_tt.

## Timing
- Reset values: stim 0, busy 0, done 0, pass 0, fail_count 0, first_fail_valid 0, first_fail_vec 0, obs_tt 0.
- Start is accepted at edge 0. busy is high after edge 0.
- Vector v is applied at edge v*(2+SETTLE_CYCLES)+1. It is sampled at edge (v+1)*(2+SETTLE_CYCLES).
- DONE is entered at edge 2**N_IN*(2+SETTLE_CYCLES)+1; done is high during that cycle.
  - Defaults: DONE at edge 65.
- A new start may be accepted in the cycle after done, i.e. at the first IDLE cycle.

## Configuration
- CELL_SEQ_OBS_TT_EN defined: in SAMPLE, obs_tt[vec] <= cell_out (X/Z stored as 0). The full observed table is available at done.
- Undefined: obs_tt is tied to 0 and the capture register is not built. All other behaviour is identical.

## Structure
- Package cell_seq_pkg holds:
  - state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE);
  - SETTLE counter width constant (8 bits);
  - NOR/NAND/AND/OR truth-table constants for N_IN = 2..4 (e.g. NOR4_TT = 16'h0001).
- One sub-module, cell_seq_settle_timer: load/count-down timer that asserts expire after SETTLE_CYCLES. It is bypassed when SETTLE_CYCLES == 0.

## Test plan
- NOR4 behavioural model, expected_tt = 16'h0001, defaults → stim walks 0..15; done at edge 65; pass = 1; fail_count 0; first_fail_valid 0; with the macro, obs_tt = 16'h0001.
- NOR4 model with ZN stuck at 0 → fail_count 1; first_fail_vec 4'h0; pass 0.
- Expected table 16'h0003 against a correct NOR4 → fail_count 1; first_fail_vec 4'h1.
- SETTLE_CYCLES = 0, N_IN = 2, NOR2 (expected_tt 4'h1) → done at edge 9; pass 1.
- abort at edge 20 → IDLE at edge 21; no done pulse; stim 0; fail_count 0. A fresh start then completes normally. start pulsed while busy has no effect.
- rst asserted mid-run at edge 30 → all outputs at reset values after edge 30.

Source files
------------

// File: rtl/cell_seq_pkg.sv
// Shared types and constants for the cell truth-table sequencer.
// Truth tables are indexed by input vector, where the MSB of the vector drives A1.
package cell_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } seq_state_t;

  localparam int SETTLE_W = 8;

  localparam logic [3:0]  NOR2_TT  = 4'h1;
  localparam logic [3:0]  NAND2_TT = 4'h7;
  localparam logic [3:0]  AND2_TT  = 4'h8;
  localparam logic [3:0]  OR2_TT   = 4'hE;

  localparam logic [7:0]  NOR3_TT  = 8'h01;
  localparam logic [7:0]  NAND3_TT = 8'h7F;
  localparam logic [7:0]  AND3_TT  = 8'h80;
  localparam logic [7:0]  OR3_TT   = 8'hFE;

  localparam logic [15:0] NOR4_TT  = 16'h0001;
  localparam logic [15:0] NAND4_TT = 16'h7FFF;
  localparam logic [15:0] AND4_TT  = 16'h8000;
  localparam logic [15:0] OR4_TT   = 16'hFFFE;

endpackage

// File: rtl/cell_seq_settle_timer.sv
// Load/count-down settle timer: loaded while a vector is applied, expire is
// high during the last settle cycle so the FSM moves to SAMPLE on that edge.
module cell_seq_settle_timer
  import cell_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                expire
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - SETTLE_W'(1);
    end
  end

  assign expire = (cnt == SETTLE_W'(1));

endmodule

// File: rtl/cell_truth_table_sequencer.sv
// Walks a combinational cell through all 2**N_IN input vectors and checks its output
// against a latched truth table. Define CELL_SEQ_OBS_TT_EN to build the observed-table capture.
module cell_truth_table_sequencer
  import cell_seq_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [(1<<N_IN)-1:0]  expected_tt,
  input  logic                  cell_out,
  output logic [N_IN-1:0]       stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         fail_count,
  output logic                  first_fail_valid,
  output logic [N_IN-1:0]       first_fail_vec,
  output logic [(1<<N_IN)-1:0]  obs_tt
);

  localparam int              VEC_N    = 1 << N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [N_IN-1:0]  vec;
  logic [VEC_N-1:0] exp_tt;
  logic             expire;
  logic             kill;
  logic             mismatch;

  assign kill     = abort && (state != IDLE);
  // 4-state compare so an X/Z cell output is reported as a failure
  assign mismatch = (cell_out !== exp_tt[vec]);

  generate
    if (SETTLE_CYCLES > 0) begin : g_timer
      cell_seq_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (kill),
        .load     (state == APPLY),
        .load_val (SETTLE_W'(SETTLE_CYCLES)),
        .expire   (expire)
      );
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (expire) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (vec == VEC_LAST) ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= '0;
      exp_tt           <= '0;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (kill) begin
        vec              <= '0;
        stim             <= '0;
        busy             <= 1'b0;
        pass             <= 1'b0;
        fail_count       <= '0;
        first_fail_valid <= 1'b0;
        first_fail_vec   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              exp_tt           <= expected_tt;
              vec              <= '0;
              busy             <= 1'b1;
              pass             <= 1'b0;
              fail_count       <= '0;
              first_fail_valid <= 1'b0;
              first_fail_vec   <= '0;
            end
          end
          APPLY: stim <= vec;
          SAMPLE: begin
            if (mismatch) begin
              fail_count <= fail_count + (N_IN+1)'(1);
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= vec;
              end
            end
            if (vec != VEC_LAST) vec <= vec + N_IN'(1);
          end
          DONE: begin
            done <= 1'b1;
            busy <= 1'b0;
            stim <= '0;
            pass <= (fail_count == '0);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CELL_SEQ_OBS_TT_EN
  logic [VEC_N-1:0] obs_q;

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      obs_q <= '0;
    end else if (state == IDLE && start) begin
      obs_q <= '0;
    end else if (state == SAMPLE) begin
      obs_q[vec] <= (cell_out === 1'b1);
    end
  end

  assign obs_tt = obs_q;
`else
  assign obs_tt = '0;
`endif

endmodule

// File: tb/tb_cell_truth_table_sequencer.sv
// Scoreboard bench: a default NOR4 sequencer and an N_IN=2 / zero-settle NOR2 sequencer.
module tb_cell_truth_table_sequencer;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a, abort_a, cell_a;
  logic [15:0] exp_a;
  logic [3:0]  stim_a;
  logic        busy_a, done_a, pass_a, ffv_a;
  logic [4:0]  fc_a;
  logic [3:0]  ffvec_a;
  logic [15:0] obs_a;

  logic        start_b, abort_b, cell_b;
  logic [3:0]  exp_b;
  logic [1:0]  stim_b;
  logic        busy_b, done_b, pass_b, ffv_b;
  logic [2:0]  fc_b;
  logic [1:0]  ffvec_b;
  logic [3:0]  obs_b;

  int checks = 0;
  int errors = 0;
  int mode_a = 0;

  typedef struct {
    logic [4:0]  fc;
    logic        ffv;
    logic [3:0]  ffvec;
    logic        pass;
    logic [15:0] obs;
  } res_t;

  res_t sb_q[$];
  int   stim_q[$];

  // Behavioural NOR cells; mode 1 models ZN stuck at 0
  assign cell_a = (mode_a == 1) ? 1'b0 : ~|stim_a;
  assign cell_b = ~|stim_b;

  always #5 clk = ~clk;

  cell_truth_table_sequencer #(.N_IN(4), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .expected_tt(exp_a),
    .cell_out(cell_a), .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fc_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a), .obs_tt(obs_a)
  );

  cell_truth_table_sequencer #(.N_IN(2), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .expected_tt(exp_b),
    .cell_out(cell_b), .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fc_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b), .obs_tt(obs_b)
  );

  function automatic logic model_a(input int m, input int v);
    if (m == 1) return 1'b0;
    return (v == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [15:0] tt, input int m, input bit pulse_busy);
    res_t r;
    res_t got;
    logic o;
    int   e;
    int   s;
    bit   seen;
    r.fc = '0; r.ffv = 1'b0; r.ffvec = '0; r.obs = '0;
    stim_q.delete();
    for (int v = 0; v < 16; v++) begin
      o = model_a(m, v);
`ifdef CELL_SEQ_OBS_TT_EN
      r.obs[v] = o;
`endif
      if (o != tt[v]) begin
        if (!r.ffv) begin
          r.ffv   = 1'b1;
          r.ffvec = 4'(v);
        end
        r.fc = r.fc + 5'd1;
      end
      stim_q.push_back(v);
    end
    r.pass = (r.fc == 5'd0);
    sb_q.push_back(r);

    mode_a  = m;
    exp_a   = tt;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b expected 1", busy_a);
    end

    e = 0;
    seen = 1'b0;
    while (!seen && e < 100) begin
      if (pulse_busy && e == 5) begin
        start_a = 1'b1;
        exp_a   = ~tt;
      end else begin
        start_a = 1'b0;
      end
      step();
      e++;
      if ((e % 4) == 1 && stim_q.size() > 0) begin
        s = stim_q.pop_front();
        checks++;
        if (stim_a !== 4'(s)) begin
          errors++;
          $display("FAIL stim_edge%0d: got %h expected %h", e, stim_a, 4'(s));
        end
      end
      if (done_a === 1'b1) seen = 1'b1;
    end
    start_a = 1'b0;
    checks++;
    if (!seen || e != 65) begin
      errors++;
      $display("FAIL done_edge: got edge %0d (seen=%0b) expected 65", e, seen);
    end

    got = sb_q.pop_front();
    checks++;
    if (fc_a !== got.fc) begin
      errors++;
      $display("FAIL fail_count: got %0d expected %0d", fc_a, got.fc);
    end
    checks++;
    if (ffv_a !== got.ffv || (got.ffv && ffvec_a !== got.ffvec)) begin
      errors++;
      $display("FAIL first_fail: got %b/%h expected %b/%h", ffv_a, ffvec_a, got.ffv, got.ffvec);
    end
    checks++;
    if (pass_a !== got.pass) begin
      errors++;
      $display("FAIL pass: got %b expected %b", pass_a, got.pass);
    end
    checks++;
    if (obs_a !== got.obs) begin
      errors++;
      $display("FAIL obs_tt: got %h expected %h", obs_a, got.obs);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: got %b expected 0", busy_a);
    end

    step();
    checks++;
    if (done_a !== 1'b0 || stim_a !== 4'h0 || pass_a !== got.pass) begin
      errors++;
      $display("FAIL after_done: got done=%b stim=%h pass=%b expected 0/0/%b",
               done_a, stim_a, pass_a, got.pass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({stim_a, busy_a, done_a, pass_a, fc_a, ffv_a, ffvec_a, obs_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got stim=%h busy=%b done=%b pass=%b fc=%0d ffv=%b ffvec=%h obs=%h expected all 0",
               stim_a, busy_a, done_a, pass_a, fc_a, ffv_a, ffvec_a, obs_a);
    end
    checks++;
    if ({stim_b, busy_b, done_b, pass_b, fc_b, ffv_b, ffvec_b, obs_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got %h expected 0",
               {stim_b, busy_b, done_b, pass_b, fc_b, ffv_b, ffvec_b, obs_b});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_nor4_pass();
    run_a(16'h0001, 0, 1'b0);
  endtask

  task automatic test_stuck_zn();
    run_a(16'h0001, 1, 1'b0);
  endtask

  task automatic test_wrong_table();
    run_a(16'h0003, 0, 1'b0);
  endtask

  task automatic test_settle_zero();
    res_t r;
    res_t got;
    logic o;
    int   e;
    int   s;
    bit   seen;
    r.fc = '0; r.ffv = 1'b0; r.ffvec = '0; r.obs = '0;
    stim_q.delete();
    for (int v = 0; v < 4; v++) begin
      o = (v == 0);
`ifdef CELL_SEQ_OBS_TT_EN
      r.obs[v] = o;
`endif
      if (o != ((4'h1 >> v) & 4'h1)) r.fc = r.fc + 5'd1;
      stim_q.push_back(v);
    end
    r.pass = (r.fc == 5'd0);
    sb_q.push_back(r);

    exp_b   = 4'h1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    e = 0;
    seen = 1'b0;
    while (!seen && e < 40) begin
      step();
      e++;
      if ((e % 2) == 1 && stim_q.size() > 0) begin
        s = stim_q.pop_front();
        checks++;
        if (stim_b !== 2'(s)) begin
          errors++;
          $display("FAIL stim_b_edge%0d: got %h expected %h", e, stim_b, 2'(s));
        end
      end
      if (done_b === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || e != 9) begin
      errors++;
      $display("FAIL done_edge_b: got edge %0d (seen=%0b) expected 9", e, seen);
    end
    got = sb_q.pop_front();
    checks++;
    if (pass_b !== got.pass || {2'b00, fc_b} !== got.fc || ffv_b !== 1'b0) begin
      errors++;
      $display("FAIL result_b: got pass=%b fc=%0d ffv=%b expected %b/%0d/0",
               pass_b, fc_b, ffv_b, got.pass, got.fc);
    end
    checks++;
    if ({12'h000, obs_b} !== got.obs) begin
      errors++;
      $display("FAIL obs_b: got %h expected %h", obs_b, got.obs);
    end
    step();
  endtask

  task automatic test_abort();
    bit pulsed;
    mode_a  = 1;
    exp_a   = 16'h0001;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (20) step();
    checks++;
    if (fc_a !== 5'd1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: got fc=%0d busy=%b expected 1/1", fc_a, busy_a);
    end
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || stim_a !== 4'h0 || fc_a !== 5'd0 || ffv_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL post_abort: got busy=%b stim=%h fc=%0d ffv=%b done=%b expected all 0",
               busy_a, stim_a, fc_a, ffv_a, done_a);
    end
    pulsed = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done_a === 1'b1 || busy_a === 1'b1) pulsed = 1'b1;
    end
    checks++;
    if (pulsed) begin
      errors++;
      $display("FAIL abort_quiet: got activity=1 expected 0");
    end
    run_a(16'h0001, 0, 1'b1);
  endtask

  task automatic test_rst_mid();
    mode_a  = 1;
    exp_a   = 16'h0001;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (29) step();
    rst = 1'b1;
    step();
    checks++;
    if ({stim_a, busy_a, done_a, pass_a, fc_a, ffv_a, ffvec_a, obs_a} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got stim=%h busy=%b done=%b pass=%b fc=%0d ffv=%b ffvec=%h obs=%h expected all 0",
               stim_a, busy_a, done_a, pass_a, fc_a, ffv_a, ffvec_a, obs_a);
    end
    rst = 1'b0;
    step();
    run_a(16'h0001, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; exp_a = '0;
    start_b = 1'b0; abort_b = 1'b0; exp_b = '0;
    test_reset();
    test_nor4_pass();
    test_stuck_zn();
    test_wrong_table();
    test_settle_zero();
    test_abort();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
